// File: rtl/saes64_lockstep_checker.sv
// saes64_lockstep_checker: lockstep comparator for NCH redundant saes64 result
// channels. Each channel feeds a small skew FIFO; complete result sets pop
// together and are compared against channel 0. Skew timeout, FIFO overflow and
// data mismatch are reported through a first-error-wins latch.
// Build option: define SAES64_LOCKSTEP_HALT_EN to make a data mismatch halt
// the checker as well (timeout and overflow always halt).
module saes64_lockstep_checker #(
  parameter int NCH     = 2,
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic [NCH-1:0]       res_valid,
  input  logic [NCH*WIDTH-1:0] res_data,
  input  logic                 clear,
  output logic                 cmp_valid,
  output logic [WIDTH-1:0]     cmp_data,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [1:0]           err_code,
  output logic [15:0]          mismatch_cnt,
  output logic                 busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
`ifdef SAES64_LOCKSTEP_HALT_EN
  localparam logic       HALT_ON_MM = 1'b1;
`else
  localparam logic       HALT_ON_MM = 1'b0;
`endif
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_MM   = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SKEW = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d, occ_state_s;
  logic [AW:0]      wptr_q [NCH];
  logic [AW:0]      wptr_d [NCH];
  logic [AW:0]      rptr_q [NCH];
  logic [AW:0]      rptr_d [NCH];
  logic [AW:0]      wptr_n_s [NCH];
  logic [AW:0]      rptr_n_s [NCH];
  logic [WIDTH-1:0] mem_q [NCH][DEPTH];
  logic [WIDTH-1:0] head_s [NCH];
  logic [NCH-1:0]   ne_s, full_s, wr_s, ne_n_s;
  logic             halted_s, pop_s, ovf_s, tmo_s, diff_s, mm_s, halt_s;
  logic [1:0]       ev_code_s;
  logic [7:0]       skew_q, skew_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic [WIDTH-1:0] cmp_data_q, cmp_data_d;
  logic             mismatch_q, mismatch_d;
  logic             err_sticky_q, err_sticky_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [15:0]      mcnt_q, mcnt_d;

  // Occupancy flags and head entries derived from the registered pointers.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ne_s[i]   = (wptr_q[i] != rptr_q[i]);
      full_s[i] = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                  (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
      head_s[i] = mem_q[i][rptr_q[i][AW-1:0]];
    end
  end

  // Per-cycle events: pop, overflow, timeout, data difference, next occupancy.
  always_comb begin
    halted_s = (state_q == ST_HALT);
    pop_s    = (&ne_s) && !halted_s;
    if (halted_s) begin
      wr_s = {NCH{1'b0}};
    end else begin
      wr_s = res_valid;
    end
    // A write into a full FIFO is only legal when that FIFO pops this cycle.
    ovf_s  = |(wr_s & full_s & ~{NCH{pop_s}});
    diff_s = 1'b0;
    for (int i = 1; i < NCH; i++) begin
      if (head_s[i] != head_s[0]) begin
        diff_s = 1'b1;
      end else begin
        diff_s = diff_s;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      wptr_n_s[i] = wptr_q[i] + {{AW{1'b0}}, wr_s[i]};
      rptr_n_s[i] = rptr_q[i] + {{AW{1'b0}}, pop_s};
      ne_n_s[i]   = (wptr_n_s[i] != rptr_n_s[i]);
    end
    if ((&ne_n_s) || !(|ne_n_s)) begin
      occ_state_s = ST_RUN;
    end else begin
      occ_state_s = ST_SKEW;
    end
    tmo_s = (state_q == ST_SKEW) && (occ_state_s == ST_SKEW) &&
            ((skew_q + 8'd1) >= TO_LIMIT);
    mm_s  = pop_s && diff_s && !ovf_s;
    // Simultaneous events resolve as overflow > timeout > mismatch.
    if (ovf_s) begin
      ev_code_s = ERR_OVF;
    end else if (tmo_s) begin
      ev_code_s = ERR_TMO;
    end else if (mm_s) begin
      ev_code_s = ERR_MM;
    end else begin
      ev_code_s = ERR_NONE;
    end
    halt_s = ovf_s || tmo_s || (mm_s && HALT_ON_MM);
  end

  // FSM next state, FIFO pointers, comparison result and error latch.
  always_comb begin
    state_d      = state_q;
    skew_d       = skew_q;
    cmp_valid_d  = 1'b0;
    cmp_data_d   = cmp_data_q;
    mismatch_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    err_code_d   = err_code_q;
    mcnt_d       = mcnt_q;
    for (int i = 0; i < NCH; i++) begin
      wptr_d[i] = wptr_n_s[i];
      rptr_d[i] = rptr_n_s[i];
    end
    if (clear) begin
      // Clear overrides every event raised in the same cycle.
      for (int i = 0; i < NCH; i++) begin
        wptr_d[i] = {(AW+1){1'b0}};
        rptr_d[i] = {(AW+1){1'b0}};
      end
      state_d      = ST_RUN;
      skew_d       = 8'd0;
      err_sticky_d = 1'b0;
      err_code_d   = ERR_NONE;
      mcnt_d       = 16'd0;
    end else if (halted_s) begin
      // Frozen: keep FIFOs empty and ignore all channel traffic.
      for (int i = 0; i < NCH; i++) begin
        wptr_d[i] = wptr_q[i];
        rptr_d[i] = wptr_q[i];
      end
      state_d = ST_HALT;
      skew_d  = 8'd0;
    end else begin
      cmp_valid_d = pop_s && !ovf_s && !tmo_s;
      if (cmp_valid_d) begin
        cmp_data_d = head_s[0];
        mismatch_d = mm_s;
      end else begin
        cmp_data_d = cmp_data_q;
        mismatch_d = 1'b0;
      end
      if (mm_s && (mcnt_q != 16'hFFFF)) begin
        mcnt_d = mcnt_q + 16'd1;
      end else begin
        mcnt_d = mcnt_q;
      end
      if ((ev_code_s != ERR_NONE) && !err_sticky_q) begin
        err_sticky_d = 1'b1;
        err_code_d   = ev_code_s;
      end else begin
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
      end
      if (halt_s) begin
        state_d = ST_HALT;
        skew_d  = 8'd0;
        for (int i = 0; i < NCH; i++) begin
          rptr_d[i] = wptr_n_s[i];
        end
      end else begin
        state_d = occ_state_s;
        if ((state_q == ST_SKEW) && (occ_state_s == ST_SKEW)) begin
          skew_d = skew_q + 8'd1;
        end else begin
          skew_d = 8'd0;
        end
      end
    end
  end

  // Control/status registers; storage array below carries no reset.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= ST_RUN;
      skew_q       <= 8'd0;
      cmp_valid_q  <= 1'b0;
      cmp_data_q   <= {WIDTH{1'b0}};
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= ERR_NONE;
      mcnt_q       <= 16'd0;
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= {(AW+1){1'b0}};
        rptr_q[i] <= {(AW+1){1'b0}};
      end
    end else begin
      state_q      <= state_d;
      skew_q       <= skew_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_data_q   <= cmp_data_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
      mcnt_q       <= mcnt_d;
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // FIFO storage write port; an entry becomes visible once the pointer moves.
  always_ff @(posedge g_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr_s[i] && !clear) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= res_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign cmp_valid    = cmp_valid_q;
  assign cmp_data     = cmp_data_q;
  assign mismatch     = mismatch_q;
  assign err_sticky   = err_sticky_q;
  assign err_code     = err_code_q;
  assign mismatch_cnt = mcnt_q;
  assign busy         = |ne_s;

endmodule

// File: doc/saes64_lockstep_checker.md
SAES64_LOCKSTEP_CHECKER -- requirements
Module: saes64_lockstep_checker

Interface
REQ-001 Parameter NCH, default 2: number of redundant saes64 result channels compared in lockstep, legal range 2..4.
REQ-002 Parameter WIDTH, default 64: result width per channel.
REQ-003 Parameter DEPTH, default 4: per-channel skew buffer depth, power of 2, at least 2.
REQ-004 Parameter TIMEOUT, default 16: maximum cycles of inter-channel skew, range 1..255.
REQ-005 g_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 g_resetn  in  1  asynchronous, active-low reset.
REQ-007 res_valid  in  NCH  per-channel result strobe (the channel's ready).
REQ-008 res_data  in  NCH*WIDTH  per-channel result (rd); channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 clear  in  1  single-cycle request to clear errors, counter and buffers.
REQ-010 cmp_valid  out  1  one-cycle pulse, one compared result set.
REQ-011 cmp_data  out  WIDTH  channel-0 value of the compared set.
REQ-012 mismatch  out  1  qualified by cmp_valid; any channel differs from channel 0.
REQ-013 err_sticky  out  1  latched error flag.
REQ-014 err_code  out  2  0 none, 1 mismatch, 2 timeout, 3 overflow.
REQ-015 mismatch_cnt  out  16  mismatching sets since reset/clear.
REQ-016 busy  out  1  any skew buffer non-empty.

Function
REQ-017 Each channel SHALL own a DEPTH-entry FIFO written with res_data on res_valid.
REQ-018 When all FIFOs are non-empty, all heads SHALL pop in the same cycle; the registered comparison result SHALL assert cmp_valid exactly one cycle after the pop.
- Minimum latency: last channel's res_valid sampled at edge k -> pop at edge k+1 -> cmp_valid high in the cycle after edge k+1.
REQ-019 Up to one set SHALL pop per cycle; back-to-back sets SHALL give back-to-back cmp_valid.
REQ-020 The FSM SHALL have three states:
- RUN: all FIFOs empty or all FIFOs non-empty.
- SKEW: some but not all FIFOs non-empty.
- HALT: error latched; outputs frozen.
REQ-021 In SKEW, an 8-bit skew counter SHALL increment every cycle; it SHALL reset to 0 on leaving SKEW.
- Counter reaching TIMEOUT: err_code=2 and enter HALT.
REQ-022 res_valid on a channel whose FIFO is full and not popping in the same cycle SHALL set err_code=3 and enter HALT.
- A write to a full FIFO that pops in the same cycle is legal.
REQ-023 A mismatching set SHALL pulse mismatch with cmp_valid and increment mismatch_cnt, which saturates at 0xFFFF.
- First mismatch sets err_sticky and err_code=1.
REQ-024 Only the first error SHALL be latched into err_code; for simultaneous events, priority is overflow > timeout > mismatch.
REQ-025 In HALT, all FIFOs SHALL be flushed, res_valid SHALL be ignored, and cmp_valid and mismatch SHALL be held 0.
REQ-026 clear SHALL, at the next edge:
- flush all FIFOs;
- zero err_sticky, err_code, mismatch_cnt and the skew counter;
- enter RUN.
- clear wins over any error event in the same cycle; the event is discarded.
REQ-027 busy SHALL be the OR of FIFO non-empty flags, combinational from registered state.

Reset
REQ-028 While g_resetn=0:
- FIFOs empty, FSM=RUN, skew counter=0.
- cmp_valid=0, cmp_data=0, mismatch=0, err_sticky=0, err_code=0, mismatch_cnt=0, busy=0.
REQ-029 Reset asserted mid-set SHALL discard partial sets; no cmp_valid SHALL follow reset release without fresh res_valid on all channels.

Configuration
REQ-030 Macro SAES64_LOCKSTEP_HALT_EN.
- Defined: a data mismatch also enters HALT after its cmp_valid pulse.
- Undefined: a mismatch only counts and latches err_sticky/err_code, and comparison continues in RUN/SKEW; timeout and overflow halt in both builds.

Verification
REQ-031 NCH=2, both channels res_valid with 0x0123456789ABCDEF at the same edge -> one cmp_valid two edges later, mismatch=0, cmp_data=0x0123456789ABCDEF.
REQ-032 NCH=2, ch1 = ch0 XOR 1 -> mismatch=1, mismatch_cnt=1, err_code=1; a HALT_EN build then ignores a following matching set.
REQ-033 NCH=3, ch2 lags ch0/ch1 by 5 cycles for 3 sets -> 3 cmp_valid in order, no error, busy drops after the last pop.
REQ-034 TIMEOUT=16, only ch0 pulses -> err_code=2 exactly 16 cycles after entering SKEW, HALT, busy=0 next cycle.
REQ-035 DEPTH=4, ch0 pulses 5 times while ch1 is silent -> err_code=3 on the 5th write; clear asserted together with a 6th write -> err_code=0, RUN.
REQ-036 Assert g_resetn=0 with one channel holding 2 entries -> all outputs 0 immediately; no cmp_valid after release.
